// File: rtl/aca_recover_n32_q8_if.sv
// Operand/result handshake bundle for the approximate adder with recovery.
// master: the producer/consumer side; slave: the adder block.
interface aca_recover_n32_q8_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] res;
    logic        corrected;

    modport master (
        output in_valid,
        output in1,
        output in2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  res,
        input  corrected
    );

    modport slave (
        input  in_valid,
        input  in1,
        input  in2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output res,
        output corrected
    );
endinterface

// File: rtl/aca_recover_n32_q8.sv
// 32-bit approximate adder (8-bit carry window) with error detection and a
// byte-serial ripple recovery path. Fast results appear one cycle after the
// transfer. Mispredicted sums take four FIX cycles to rebuild exactly.
// err_cnt counts corrections and saturates.
module aca_recover_n32_q8 #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aca_recover_n32_q8_if.slave  bus,
    input  logic                 err_clr,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FIX  = 2'b01,
        HOLD = 2'b10
    } state_t;

    // Each sum bit i >= 8 only sees the carry produced inside the 8-bit window
    // ending at bit i. Bit 32 is the carry out of the top byte alone.
    function automatic logic [32:0] approx_sum(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        logic [8:0]  s;
        r      = 33'd0;
        s      = {1'b0, a[7:0]} + {1'b0, b[7:0]};
        r[7:0] = s[7:0];
        for (int i = 8; i < 32; i++) begin
            s    = {1'b0, a[i -: 8]} + {1'b0, b[i -: 8]};
            r[i] = s[7];
        end
        s     = {1'b0, a[31:24]} + {1'b0, b[31:24]};
        r[32] = s[8];
        return r;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [31:0]        a_r;
    logic [31:0]        a_next_s;
    logic [31:0]        b_r;
    logic [31:0]        b_next_s;
    logic [32:0]        res_r;
    logic [32:0]        res_next_s;
    logic               corr_r;
    logic               corr_next_s;
    logic [1:0]         k_r;
    logic [1:0]         k_next_s;
    logic               carry_r;
    logic               carry_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               cnt_inc_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [32:0]        approx_s;
    logic [32:0]        exact_s;
    logic               err_flag_s;
    logic [8:0]         byte_sum_s;

    // Approximate and exact sums of the presented operands, and their disagreement.
    always_comb begin
        approx_s   = approx_sum(bus.in1, bus.in2);
        exact_s    = {1'b0, bus.in1} + {1'b0, bus.in2};
        err_flag_s = (approx_s != exact_s);
    end

    // One byte of the exact ripple addition, selected by the byte index.
    always_comb begin
        byte_sum_s = {1'b0, a_r[{k_r, 3'b000} +: 8]}
                   + {1'b0, b_r[{k_r, 3'b000} +: 8]}
                   + {8'd0, carry_r};
    end

    // Next-state and datapath updates for IDLE/FIX/HOLD.
    always_comb begin
        state_next_s = state_r;
        a_next_s     = a_r;
        b_next_s     = b_r;
        res_next_s   = res_r;
        corr_next_s  = corr_r;
        k_next_s     = k_r;
        carry_next_s = carry_r;
        cnt_inc_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next_s     = bus.in1;
                    b_next_s     = bus.in2;
                    res_next_s   = approx_s;
                    corr_next_s  = err_flag_s;
                    k_next_s     = 2'd0;
                    carry_next_s = 1'b0;
                    state_next_s = err_flag_s ? FIX : HOLD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FIX: begin
                res_next_s[{k_r, 3'b000} +: 8] = byte_sum_s[7:0];
                carry_next_s = byte_sum_s[8];
                k_next_s     = k_r + 2'd1;
                if (k_r == 2'd3) begin
                    res_next_s[32] = byte_sum_s[8];
                    cnt_inc_s      = 1'b1;
                    state_next_s   = HOLD;
                end else begin
                    state_next_s = FIX;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Saturating correction counter; a clear overrides a coincident increment.
    always_comb begin
        if (err_clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_inc_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State, operand, result and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= 32'd0;
            b_r         <= 32'd0;
            res_r       <= 33'd0;
            corr_r      <= 1'b0;
            k_r         <= 2'd0;
            carry_r     <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            a_r         <= a_next_s;
            b_r         <= b_next_s;
            res_r       <= res_next_s;
            corr_r      <= corr_next_s;
            k_r         <= k_next_s;
            carry_r     <= carry_next_s;
            cnt_r       <= cnt_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == HOLD);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.res       = res_r;
    assign bus.corrected = corr_r;
    assign err_cnt       = cnt_r;

endmodule

// File: tb/tb_aca_recover_n32_q8.sv
// Scoreboard bench for aca_recover_n32_q8: a cycle-level reference model
// pushes expected results at each accepted transfer; a negedge monitor
// compares handshake flags, result fields and the correction counter.
module tb_aca_recover_n32_q8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    aca_recover_n32_q8_if bus();

    aca_recover_n32_q8 #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .err_clr (err_clr),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] res;
        logic        corr;
        int          c0;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   mcnt = 0;
    bit   pend = 1'b0;
    int   pend_cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;
    bit   mon_en = 1'b0;
    bit   rand_clr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        ncmp++;
        nerr++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Approximate sum from its definition: each bit i>=8 is bit 7 of the sum
    // of the 8-bit windows ending at bit i.
    function automatic logic [32:0] ref_approx(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        logic [63:0] s;
        r = 33'd0;
        s = (64'(a) & 64'hFF) + (64'(b) & 64'hFF);
        r[7:0] = s[7:0];
        for (int i = 8; i < 32; i++) begin
            s = ((64'(a) >> (i - 7)) & 64'hFF) + ((64'(b) >> (i - 7)) & 64'hFF);
            r[i] = s[7];
        end
        s = (64'(a) >> 24) + (64'(b) >> 24);
        r[32] = s[8];
        return r;
    endfunction

    // Reference model: acceptance, output handshake and counter at each edge.
    always @(posedge clk) begin
        bit          idle_m;
        exp_t        e;
        logic [63:0] ex;
        if (rst_n && mon_en) begin
            idle_m = (q.size() == 0);
            if (!idle_m && (cyc - q[0].c0 >= q[0].lat) && bus.out_ready)
                void'(q.pop_front());
            if (idle_m && bus.in_valid) begin
                ex     = 64'(bus.in1) + 64'(bus.in2);
                e.res  = ex[32:0];
                e.corr = (ref_approx(bus.in1, bus.in2) != ex[32:0]);
                e.c0   = cyc;
                e.lat  = e.corr ? 5 : 1;
                q.push_back(e);
                if (e.corr) begin
                    pend     = 1'b1;
                    pend_cyc = cyc + 4;
                end
            end
            if (err_clr)
                mcnt = 0;
            else if (pend && cyc == pend_cyc && mcnt < (1 << CNT_W) - 1)
                mcnt++;
            if (pend && cyc == pend_cyc)
                pend = 1'b0;
            cyc++;
        end
    end

    // Reset aborts any operation in flight and clears the counter.
    always @(negedge rst_n) begin
        q.delete();
        mcnt = 0;
        pend = 1'b0;
    end

    // Monitor: compare DUT outputs against the scoreboard head.
    always @(negedge clk) begin
        bit eov;
        if (mon_en) begin
            eov = (q.size() > 0) && (cyc - q[0].c0 >= q[0].lat);
            chk("in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
            chk("out_valid", 64'(bus.out_valid), 64'(eov));
            chk("err_cnt", 64'(err_cnt), 64'(mcnt));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    chk("res", 64'(bus.res), 64'(q[0].res));
                    chk("corrected", 64'(bus.corrected), 64'(q[0].corr));
                end
            end
        end
    end

    task automatic nclk();
        @(negedge clk);
        err_clr = rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int delay, input bit poke);
        int t;
        t = 0;
        while (!bus.in_ready && t < 50) begin nclk(); t++; end
        if (t >= 50) timeout("in_ready_wait");
        bus.in_valid = 1'b1;
        bus.in1 = a;
        bus.in2 = b;
        nclk();
        bus.in_valid = 1'b0;
        bus.in1 = $urandom;
        bus.in2 = $urandom;
        t = 0;
        while (!bus.out_valid && t < 20) begin nclk(); t++; end
        if (t >= 20) timeout("out_valid_wait");
        for (int i = 0; i < delay; i++) begin
            bus.in_valid = (poke && i == 0);
            nclk();
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        nclk();
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_res", 64'(bus.res), 64'd0);
        chk("rst_corrected", 64'(bus.corrected), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    endtask

    // Watchdog against a hung simulation.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed cases followed by randomized traffic.
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bus.in_valid  = 1'b0;
        bus.in1       = 32'd0;
        bus.in2       = 32'd0;
        bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        mon_en = 1'b1;
        #2 chk_reset_vals();
        nclk();
        nclk();
        rst_n = 1'b1;

        do_op(32'h00000001, 32'h00000002, 0, 1'b0);
        do_op(32'h000000FF, 32'h00000001, 0, 1'b0);
        chk("cnt_after_first_fix", 64'(err_cnt), 64'd1);
        do_op(32'hFFFFFFFF, 32'h00000001, 0, 1'b0);
        do_op(32'h80000000, 32'h80000000, 0, 1'b0);
        do_op(32'h12345678, 32'h01010101, 3, 1'b1);
        do_op(32'h000000FF, 32'h00000001, 3, 1'b1);

        // Clear coinciding with the increment of a correction.
        bus.in_valid = 1'b1;
        bus.in1 = 32'h000000FF;
        bus.in2 = 32'h00000001;
        nclk();
        bus.in_valid = 1'b0;
        nclk();
        nclk();
        nclk();
        err_clr = 1'b1;
        nclk();
        chk("clr_wins", 64'(err_cnt), 64'd0);
        chk("clr_out_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        nclk();
        bus.out_ready = 1'b0;

        // Saturation at CNT_W bits.
        for (int i = 0; i < 4; i++) do_op(32'h000000FF, 32'h00000001, 0, 1'b0);
        chk("cnt_saturated", 64'(err_cnt), 64'd3);

        // Reset during the second FIX cycle aborts the operation.
        bus.in_valid = 1'b1;
        bus.in1 = 32'h0000FFFF;
        bus.in2 = 32'h00000001;
        nclk();
        bus.in_valid = 1'b0;
        nclk();
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        nclk();
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        nclk();

        rand_clr = 1'b1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = ~a + 32'($urandom_range(0, 3)); end
                2: begin a = ($urandom & 32'hFFFF0000) | 32'h0000FFFF; b = 32'($urandom_range(1, 4)); end
                default: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(0, 255)); end
            endcase
            do_op(a, b, $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
        end
        rand_clr = 1'b0;
        nclk();
        nclk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/aca_recover_n32_q8.md
ACA_RECOVER_N32_Q8 -- requirements
Module: aca_recover_n32_q8

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating correction counter.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand pair present.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in1  input  32  operand A, unsigned.
REQ-007 in2  input  32  operand B, unsigned.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 res  output  33  exact sum in1+in2.
REQ-011 corrected  output  1  the approximate sum was wrong and the correction path produced res.
REQ-012 err_cnt  output  CNT_W  number of corrections since reset or the last clear; saturating.
REQ-013 err_clr  input  1  synchronous clear of err_cnt.

Function
REQ-014 The approximate sum SHALL be defined as follows:
- approx[7:0] = (in1[7:0]+in2[7:0])[7:0].
- For i=8..31, approx[i] = bit 7 of the 9-bit sum in1[i:i-7]+in2[i:i-7].
- approx[32] = bit 8 of in1[31:24]+in2[31:24].
REQ-015 The error flag SHALL be 1 exactly when approx differs from the exact 33-bit sum.
REQ-016 The block SHALL have three states: IDLE, FIX and HOLD.
REQ-017 in_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-018 On the transfer edge, the block SHALL:
- register in1 and in2;
- load the result register with approx;
- load the corrected register with the error flag;
- go to HOLD if the flag is 0, or to FIX if it is 1, with byte index 0 and carry 0.
REQ-019 In FIX, each cycle SHALL perform a byte-serial ripple step:
- result[8k+7:8k] = a[8k+7:8k] + b[8k+7:8k] + carry, for byte index k;
- carry is updated to the carry-out of that byte;
- k increments.
REQ-020 After the step with k=3, the block SHALL set result[32] to the final carry, increment err_cnt, and go to HOLD.
REQ-021 err_cnt SHALL saturate at all-ones.
REQ-022 In HOLD, out_valid SHALL be 1, and res and corrected SHALL show the registered values, stable until the handshake.
REQ-023 In HOLD, out_ready=1 SHALL complete the output transfer; the block returns to IDLE on the next edge and drops out_valid.
REQ-024 Latency from the transfer edge to out_valid SHALL be:
- 1 cycle on the fast path (no error);
- 5 cycles on the correction path (4 FIX cycles, then HOLD).
REQ-025 out_valid SHALL be 0 in IDLE and FIX; in_valid is ignored outside IDLE.
REQ-026 err_clr=1 SHALL zero err_cnt on the next edge.
REQ-027 If err_clr=1 coincides with an err_cnt increment, the clear SHALL win.
REQ-028 Maximum throughput SHALL be one operation per 2 cycles (fast path) or per 6 cycles (corrected path); there is no same-cycle output-to-input overlap.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force:
- state IDLE;
- in_ready=1, out_valid=0;
- res=0, corrected=0, err_cnt=0;
- operand registers, byte index and carry to 0.
REQ-030 An assertion of rst_n in FIX or HOLD SHALL abort the operation; no result is produced for it.
REQ-031 The first transfer SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-032 Fast path: 0x00000001 + 0x00000002 -> out_valid at T+1, res=0x000000003, corrected=0, err_cnt unchanged.
REQ-033 Short-chain error: 0x000000FF + 0x00000001 (approx=0) -> out_valid at T+5, res=0x000000100, corrected=1, err_cnt=1.
REQ-034 Full-width carry: 0xFFFFFFFF + 0x00000001 -> res=0x100000000 at T+5, corrected=1.
REQ-035 Top carry only: 0x80000000 + 0x80000000 -> res=0x100000000 at T+1, corrected=0.
REQ-036 Backpressure: out_ready=0 for 3 cycles in HOLD -> out_valid, res and corrected held, in_ready=0, and an in_valid pulse is ignored; one out_ready -> IDLE next cycle.
REQ-037 Reset and counter:
- rst_n low during the second FIX cycle -> all outputs at reset values, in_ready=1 after release;
- err_clr together with a correction -> err_cnt=0;
- with CNT_W=2, 4 corrections -> err_cnt=3.
